// File: rtl/serial_tx.sv
// ---------------------------------------------------------------------------
// serial_tx -- parallel-to-serial transmitter with a one-word holding buffer.
//
// A word accepted while idle is loaded straight into the shift register and
// streamed out one bit per i_ce cycle. A word accepted while shifting waits in
// the holding buffer and follows the current word with no gap.
//
// Ports
//   i_clk        clock, all state changes on its rising edge
//   i_reset_n    asynchronous active-low reset
//   i_ce         bit-rate enable; each i_ce=1 cycle consumes the bit on o_data
//   i_valid      upstream word valid
//   o_ready      block can accept a word this cycle
//   i_word       parallel word, taken when i_valid && o_ready
//   o_data       serial bit (0 while idle)
//   o_frame      o_data carries a valid word bit
//   o_first      o_data carries the first bit of a word
//   o_busy       shifting, or the holding buffer is occupied
//   o_dbg_state  FSM state for observation (0 = IDLE, 1 = SHIFT)
//
// Handshake: a word transfers on every rising edge where i_valid and o_ready
// are both 1. o_ready depends only on internal state (never on i_valid), and
// i_valid/i_word are ignored whenever o_ready is 0.
// ---------------------------------------------------------------------------
module serial_tx #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_ce,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_data,
  output logic             o_frame,
  output logic             o_first,
  output logic             o_busy,
  output logic             o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign o_ready = !hold_full;
  assign accept  = i_valid && !hold_full;

  // Move the register one place toward the output end, zero filling.
  assign shifted = (LSB_FIRST != 0) ? {1'b0, shreg[WIDTH-1:1]}
                                    : {shreg[WIDTH-2:0], 1'b0};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
    end
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    hold_n      = hold;
    hold_full_n = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          shreg_n = i_word;
          cnt_n   = LAST;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (i_ce && cnt == '0) begin
          // Final bit of the current word is being consumed this cycle.
          if (hold_full) begin
            shreg_n     = hold;
            cnt_n       = LAST;
            hold_full_n = 1'b0;
            // Only reachable if ready is ever widened; refills the buffer.
            if (accept) begin
              hold_n      = i_word;
              hold_full_n = 1'b1;
            end
          end else if (accept) begin
            // Direct load keeps the stream gapless without using the buffer.
            shreg_n = i_word;
            cnt_n   = LAST;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (i_ce) begin
            shreg_n = shifted;
            cnt_n   = cnt - CW'(1);
          end
          if (accept) begin
            hold_n      = i_word;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    o_data      = 1'b0;
    o_frame     = (state == SHIFT);
    o_first     = (state == SHIFT) && (cnt == LAST);
    o_busy      = (state == SHIFT) || hold_full;
    o_dbg_state = (state == SHIFT);
    if (state == SHIFT) begin
      o_data = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_tx -- two serial_tx instances (MSB-first and LSB-first) share the
// same stimulus. A word-level reference model (current word + bits remaining
// + optional pending word) predicts every output each cycle, and a word
// scoreboard reassembles the MSB-first stream and matches it against the
// accepted words in order.
// ---------------------------------------------------------------------------
module tb_serial_tx;

  localparam int W = 8;

  logic         clk;
  logic         i_reset_n;
  logic         i_ce;
  logic         i_valid;
  logic [W-1:0] i_word;
  logic [1:0]   o_ready, o_data, o_frame, o_first, o_busy, o_dbg_state;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state, index 0 = MSB first, 1 = LSB first.
  logic         m_active [2];
  logic [W-1:0] m_cur    [2];
  int           m_rem    [2];
  logic         m_pfull  [2];
  logic [W-1:0] m_pend   [2];

  // Word scoreboard on the MSB-first instance.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ds_w;
  int           ds_n;

  serial_tx #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_valid(i_valid),
    .o_ready(o_ready[0]), .i_word(i_word), .o_data(o_data[0]),
    .o_frame(o_frame[0]), .o_first(o_first[0]), .o_busy(o_busy[0]),
    .o_dbg_state(o_dbg_state[0])
  );

  serial_tx #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_valid(i_valid),
    .o_ready(o_ready[1]), .i_word(i_word), .o_data(o_data[1]),
    .o_frame(o_frame[1]), .o_first(o_first[1]), .o_busy(o_busy[1]),
    .o_dbg_state(o_dbg_state[1])
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0h required=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_cur[d]    = '0;
      m_rem[d]    = 0;
      m_pfull[d]  = 1'b0;
      m_pend[d]   = '0;
    end
    exp_q.delete();
    ds_n = 0;
    ds_w = '0;
  endtask

  // Next transmitted bit: position within the word depends on bit order.
  function automatic logic exp_data(input int d);
    if (!m_active[d]) return 1'b0;
    if (d == 0) return m_cur[d][m_rem[d]-1];
    return m_cur[d][W-m_rem[d]];
  endfunction

  task automatic model_update(input int d, input logic ce, input logic acc, input logic [W-1:0] w);
    logic used;
    used = 1'b0;
    if (!m_active[d]) begin
      if (acc) begin
        m_active[d] = 1'b1;
        m_cur[d]    = w;
        m_rem[d]    = W;
        used        = 1'b1;
      end
    end else if (ce) begin
      m_rem[d]--;
      if (m_rem[d] == 0) begin
        if (m_pfull[d]) begin
          m_cur[d]   = m_pend[d];
          m_rem[d]   = W;
          m_pfull[d] = 1'b0;
        end else if (acc) begin
          m_cur[d] = w;
          m_rem[d] = W;
          used     = 1'b1;
        end else begin
          m_active[d] = 1'b0;
        end
      end
    end
    if (acc && !used) begin
      m_pend[d]  = w;
      m_pfull[d] = 1'b1;
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("ready%0d", d), 32'(o_ready[d]), 32'(!m_pfull[d]));
      check($sformatf("frame%0d", d), 32'(o_frame[d]), 32'(m_active[d]));
      check($sformatf("state%0d", d), 32'(o_dbg_state[d]), 32'(m_active[d]));
      check($sformatf("busy%0d", d), 32'(o_busy[d]), 32'(m_active[d] || m_pfull[d]));
      check($sformatf("first%0d", d), 32'(o_first[d]), 32'(m_active[d] && m_rem[d] == W));
      check($sformatf("data%0d", d), 32'(o_data[d]), 32'(exp_data(d)));
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives one cycle and returns at the next one.
  task automatic step(input logic ce, input logic v, input logic [W-1:0] w, output logic acc);
    i_ce    = ce;
    i_valid = v;
    i_word  = w;
    acc     = v && !m_pfull[0];
    if (o_frame[0] && ce) begin
      if (o_first[0]) ds_n = 0;
      ds_w = {ds_w[W-2:0], o_data[0]};
      ds_n++;
      if (ds_n == W) begin
        check("word_available", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("word_value", 32'(ds_w), 32'(exp_q.pop_front()));
        ds_n = 0;
      end
    end
    if (acc) exp_q.push_back(w);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_update(d, ce, acc, w);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_data", 32'(o_data[d]), 32'd0);
      check("rst_frame", 32'(o_frame[d]), 32'd0);
      check("rst_first", 32'(o_first[d]), 32'd0);
      check("rst_busy", 32'(o_busy[d]), 32'd0);
      check("rst_ready", 32'(o_ready[d]), 32'd1);
    end
    model_reset();
    i_ce    = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    i_reset_n = 1'b1;
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic         acc;
    logic [W-1:0] pat;
    int           ph;
    int           bits;
    logic [W-1:0] pats[2];

    i_reset_n = 1'b0;
    i_ce      = 1'b0;
    i_valid   = 1'b0;
    i_word    = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Single words from idle, continuous i_ce: exact bit patterns.
    pats[0] = 8'hA5;
    pats[1] = 8'h01;
    for (int p = 0; p < 2; p++) begin
      pat = pats[p];
      step(1'b1, 1'b1, pat, acc);
      for (int i = 0; i < W; i++) begin
        check("msb_bit", 32'(o_data[0]), 32'(pat[W-1-i]));
        check("lsb_bit", 32'(o_data[1]), 32'(pat[i]));
        check("first_only_bit0", 32'(o_first[0]), 32'(i == 0));
        step(1'b1, 1'b0, '0, acc);
      end
      check("frame_after_word", 32'(o_frame[0]), 32'd0);
    end

    // i_ce every third cycle; FF, 00 back to back, then 3C while hold is full.
    ph = 0;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step(ph % 3 == 2, 1'b1, 8'hFF, acc);
      ph++;
    end
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step(ph % 3 == 2, 1'b1, 8'h00, acc);
      ph++;
    end
    check("ready_low_hold_full", 32'(o_ready[0]), 32'd0);
    bits = 0;
    acc  = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      if (ph % 3 == 2 && o_frame[0]) bits++;
      step(ph % 3 == 2, 1'b1, 8'h3C, acc);
      ph++;
    end
    check("third_word_accepted", 32'(acc), 32'd1);
    for (int k = 0; k < 200 && o_frame[0]; k++) begin
      if (ph % 3 == 2) bits++;
      step(ph % 3 == 2, 1'b0, '0, acc);
      ph++;
    end
    check("three_words_bits", 32'(bits), 32'(3 * W));
    check("three_words_drained", 32'(exp_q.size()), 32'd0);

    // New word accepted on the final-bit cycle with hold empty.
    step(1'b1, 1'b1, 8'hC3, acc);
    for (int i = 0; i < W - 1; i++) step(1'b1, 1'b0, '0, acc);
    step(1'b1, 1'b1, 8'h5A, acc);
    check("direct_load_frame", 32'(o_frame[0]), 32'd1);
    check("direct_load_first", 32'(o_first[0]), 32'd1);
    for (int i = 0; i < W + 2; i++) step(1'b1, 1'b0, '0, acc);

    // Reset mid-word with a held word.
    step(1'b1, 1'b1, 8'hA5, acc);
    step(1'b1, 1'b1, 8'h0F, acc);
    step(1'b1, 1'b0, '0, acc);
    check("held_before_reset", 32'(o_busy[0] && !o_ready[0]), 32'd1);
    do_reset();
    for (int i = 0; i < 2 * W; i++) step(1'b1, 1'b0, '0, acc);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
             W'($urandom), acc);
      end
    end
    for (int i = 0; i < 3 * W; i++) step(1'b1, 1'b0, '0, acc);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
